axi4lite_regif: RTL and testbench

AXI4LITE_REGIF -- requirements
Module: axi4lite_regif

---
 rtl/axi4lite_pkg.sv | 19 +
 rtl/axi4lite_rdlat_pipe.sv | 36 +++
 rtl/axi4lite_regif.sv | 169 ++++++++++++++++
 tb/tb_axi4lite_regif.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4lite_pkg.sv
// axi4lite_pkg: response codes and read-FSM encoding shared by the AXI4-Lite register interface.
// Rev 1.0
`default_nettype none

package axi4lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      RD_IDLE  = 2'd0,
      RD_ISSUE = 2'd1,
      RD_WAIT  = 2'd2,
      RD_RESP  = 2'd3
   } rd_state_e;

endpackage

`default_nettype wire

// File: rtl/axi4lite_rdlat_pipe.sv
// axi4lite_rdlat_pipe: delays the read-issue pulse by RD_LAT cycles to mark the rdata sample point.
// Rev 1.0
`default_nettype none

module axi4lite_rdlat_pipe #(
   parameter int RD_LAT = 1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic start_i,
   output logic sample_o
);

   generate
      if (RD_LAT == 0) begin : g_passthru
         logic unused_clk_rst;
         assign unused_clk_rst = clk_i ^ rst_ni;
         assign sample_o       = start_i;
      end else begin : g_delay
         logic [RD_LAT-1:0] shift_q;

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               shift_q <= '0;
            end else begin
               shift_q <= (shift_q << 1) | RD_LAT'(start_i);
            end
         end

         assign sample_o = shift_q[RD_LAT-1];
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/axi4lite_regif.sv
// axi4lite_regif: AXI4-Lite slave translating bus transfers into single-cycle register strobes.
// Rev 1.0
`default_nettype none

module axi4lite_regif
   import axi4lite_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int RD_LAT    = 1,
   parameter int REG_SPACE = 4096
) (
   input  logic                s_axi_clk,
   input  logic                s_axi_resetn,
   input  logic [ADDR_W-1:0]   s_axi_awaddr,
   input  logic                s_axi_awvalid,
   output logic                s_axi_awready,
   input  logic [DATA_W-1:0]   s_axi_wdata,
   input  logic [DATA_W/8-1:0] s_axi_wstrb,
   input  logic                s_axi_wvalid,
   output logic                s_axi_wready,
   output logic [1:0]          s_axi_bresp,
   output logic                s_axi_bvalid,
   input  logic                s_axi_bready,
   input  logic [ADDR_W-1:0]   s_axi_araddr,
   input  logic                s_axi_arvalid,
   output logic                s_axi_arready,
   output logic [DATA_W-1:0]   s_axi_rdata,
   output logic [1:0]          s_axi_rresp,
   output logic                s_axi_rvalid,
   input  logic                s_axi_rready,
   output logic [ADDR_W-1:0]   reg_addr,
   output logic [DATA_W-1:0]   reg_wdata,
   output logic [DATA_W/8-1:0] reg_wstrb,
   output logic                reg_wr,
   output logic                reg_rd,
   input  logic [DATA_W-1:0]   reg_rdata
);

   localparam int                STRB_W      = DATA_W / 8;
   localparam int                ALIGN_BITS  = $clog2(STRB_W);
   localparam logic [ADDR_W-1:0] ADDR_MASK   = ~ADDR_W'((1 << ALIGN_BITS) - 1);
   localparam logic [ADDR_W:0]   SPACE_LIMIT = (ADDR_W + 1)'(REG_SPACE);

   logic              ready_en_q;
   logic              aw_full_q;
   logic [ADDR_W-1:0] aw_addr_q;
   logic              w_full_q;
   logic [DATA_W-1:0] w_data_q;
   logic [STRB_W-1:0] w_strb_q;
   logic              bvalid_q;
   logic [1:0]        bresp_q;
   rd_state_e         rd_state_q, rd_state_d;
   logic [ADDR_W-1:0] ar_addr_q;
   logic [DATA_W-1:0] rdata_q;
   logic [1:0]        rresp_q;
   logic              rr_rd_pri_q;
   logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;

   logic wr_pend, rd_pend, wr_gnt, rd_gnt;
   logic wr_in_range, rd_in_range, rd_sample;

   assign wr_pend     = aw_full_q & w_full_q;
   assign rd_pend     = (rd_state_q == RD_ISSUE);
   // On a tie the op that lost the previous tie goes first.
   assign wr_gnt      = wr_pend & (~rd_pend | ~rr_rd_pri_q);
   assign rd_gnt      = rd_pend & (~wr_pend |  rr_rd_pri_q);
   assign wr_in_range = ({1'b0, aw_addr_q} < SPACE_LIMIT);
   assign rd_in_range = ({1'b0, ar_addr_q} < SPACE_LIMIT);

   assign s_axi_awready = ready_en_q & ~aw_full_q & ~bvalid_q;
   assign s_axi_wready  = ready_en_q & ~w_full_q  & ~bvalid_q;
   assign s_axi_arready = ready_en_q & (rd_state_q == RD_IDLE);
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_rvalid  = (rd_state_q == RD_RESP);
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;

   assign reg_addr_d = wr_gnt ? aw_addr_q : (rd_gnt ? ar_addr_q : reg_addr_q);
   assign reg_addr   = reg_addr_d;
   assign reg_wdata  = w_data_q;
   assign reg_wstrb  = w_strb_q;
   assign reg_wr     = wr_gnt & wr_in_range & (|w_strb_q);
   assign reg_rd     = rd_gnt & rd_in_range;

   axi4lite_rdlat_pipe #(
      .RD_LAT (RD_LAT)
   ) u_rdlat_pipe (
      .clk_i    (s_axi_clk),
      .rst_ni   (s_axi_resetn),
      .start_i  (rd_gnt),
      .sample_o (rd_sample)
   );

   always_comb begin
      rd_state_d = rd_state_q;
      case (rd_state_q)
         RD_IDLE:  if (s_axi_arvalid && s_axi_arready) rd_state_d = RD_ISSUE;
         RD_ISSUE: if (rd_gnt) rd_state_d = rd_sample ? RD_RESP : RD_WAIT;
         RD_WAIT:  if (rd_sample) rd_state_d = RD_RESP;
         RD_RESP:  if (s_axi_rready) rd_state_d = RD_IDLE;
         default:  rd_state_d = RD_IDLE;
      endcase
   end

   always_ff @(posedge s_axi_clk or negedge s_axi_resetn) begin
      if (!s_axi_resetn) begin
         ready_en_q  <= 1'b0;
         aw_full_q   <= 1'b0;
         aw_addr_q   <= '0;
         w_full_q    <= 1'b0;
         w_data_q    <= '0;
         w_strb_q    <= '0;
         bvalid_q    <= 1'b0;
         bresp_q     <= RESP_OKAY;
         rd_state_q  <= RD_IDLE;
         ar_addr_q   <= '0;
         rdata_q     <= '0;
         rresp_q     <= RESP_OKAY;
         rr_rd_pri_q <= 1'b0;
         reg_addr_q  <= '0;
      end else begin
         ready_en_q <= 1'b1;

         if (s_axi_awvalid && s_axi_awready) begin
            aw_full_q <= 1'b1;
            aw_addr_q <= s_axi_awaddr & ADDR_MASK;
         end else if (wr_gnt) begin
            aw_full_q <= 1'b0;
         end

         if (s_axi_wvalid && s_axi_wready) begin
            w_full_q <= 1'b1;
            w_data_q <= s_axi_wdata;
            w_strb_q <= s_axi_wstrb;
         end else if (wr_gnt) begin
            w_full_q <= 1'b0;
         end

         if (wr_gnt) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_in_range ? RESP_OKAY : RESP_DECERR;
         end else if (s_axi_bready) begin
            bvalid_q <= 1'b0;
         end

         if (s_axi_arvalid && s_axi_arready) begin
            ar_addr_q <= s_axi_araddr & ADDR_MASK;
         end
         rd_state_q <= rd_state_d;

         if (rd_sample) begin
            rdata_q <= rd_in_range ? reg_rdata : '0;
            rresp_q <= rd_in_range ? RESP_OKAY : RESP_DECERR;
         end

         if (wr_pend && rd_pend) begin
            rr_rd_pri_q <= wr_gnt;
         end
         if (wr_gnt || rd_gnt) begin
            reg_addr_q <= reg_addr_d;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_axi4lite_regif.sv
// tb_axi4lite_regif: table, directed and randomized checks of axi4lite_regif against a word-memory model.
// Rev 1.0
`default_nettype none

module tb_axi4lite_regif;

   localparam int RD_LAT    = 2;
   localparam int REG_SPACE = 4096;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
   logic [3:0]  wstrb = '0;
   logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;
   logic [31:0] reg_addr, reg_wdata, reg_rdata;
   logic [3:0]  reg_wstrb;
   logic        reg_wr, reg_rd;

   int vectors = 0;
   int miscompares = 0;
   int wr_pulses = 0;
   int rd_pulses = 0;
   logic [31:0] last_wr_addr = '0;
   logic [31:0] mem       [0:1023] = '{default: '0};
   logic [31:0] model_mem [0:1023] = '{default: '0};
   logic        st_v [0:RD_LAT] = '{default: 1'b0};
   logic [31:0] st_d [0:RD_LAT] = '{default: '0};
   logic        rd_override = 1'b0;
   logic [31:0] rd_force = '0;

   always #5 clk = ~clk;

   axi4lite_regif #(
      .DATA_W(32), .ADDR_W(32), .RD_LAT(RD_LAT), .REG_SPACE(REG_SPACE)
   ) dut (
      .s_axi_clk(clk), .s_axi_resetn(resetn),
      .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb),
      .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_rdata(reg_rdata)
   );

   // Register-side responder: data is valid only exactly RD_LAT cycles after reg_rd.
   assign reg_rdata = rd_override ? rd_force : (st_v[RD_LAT] ? st_d[RD_LAT] : 32'hBAD0_BAD0);

   always @(negedge clk) begin
      if (reg_wr) begin
         wr_pulses    <= wr_pulses + 1;
         last_wr_addr <= reg_addr;
         for (int b = 0; b < 4; b++)
            if (reg_wstrb[b]) mem[reg_addr[11:2]][8*b +: 8] <= reg_wdata[8*b +: 8];
      end
      if (reg_rd) rd_pulses <= rd_pulses + 1;
      st_v[0] <= reg_rd;
      st_d[0] <= mem[reg_addr[11:2]];
      for (int i = 1; i <= RD_LAT; i++) begin
         st_v[i] <= st_v[i-1];
         st_d[i] <= st_d[i-1];
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: no response within cycle budget", name);
   endtask

   function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      if (a < REG_SPACE)
         for (int b = 0; b < 4; b++)
            if (s[b]) model_mem[a[11:2]][8*b +: 8] = d[8*b +: 8];
   endfunction

   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output int nwr);
      int  n0, t;
      bit  aw_hit, w_hit;
      n0 = wr_pulses;
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; t = 0;
      while ((awvalid || wvalid) && t < 20) begin
         @(negedge clk);
         aw_hit = awvalid && awready;
         w_hit  = wvalid && wready;
         @(posedge clk); #1;
         if (aw_hit) awvalid = 1'b0;
         if (w_hit)  wvalid  = 1'b0;
         t++;
      end
      if (awvalid || wvalid) timeout("wr_accept");
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1; t = 0;
      @(negedge clk);
      while (!bvalid && t < 20) begin @(negedge clk); t++; end
      if (!bvalid) timeout("bvalid");
      resp = bresp;
      @(posedge clk); #1;
      bready = 1'b0;
      nwr = wr_pulses - n0;
   endtask

   task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                           output int nrd);
      int  n0, t;
      bit  hit;
      n0 = rd_pulses;
      araddr = a; arvalid = 1'b1; t = 0;
      while (arvalid && t < 20) begin
         @(negedge clk);
         hit = arready;
         @(posedge clk); #1;
         if (hit) arvalid = 1'b0;
         t++;
      end
      if (arvalid) timeout("ar_accept");
      arvalid = 1'b0; rready = 1'b1; t = 0;
      @(negedge clk);
      while (!rvalid && t < 20) begin @(negedge clk); t++; end
      if (!rvalid) timeout("rvalid");
      d = rdata; resp = rresp;
      @(posedge clk); #1;
      rready = 1'b0;
      nrd = rd_pulses - n0;
   endtask

   typedef struct {
      logic [31:0] waddr; logic [31:0] wdat; logic [3:0] strb; logic [1:0] bresp; int nwr;
      logic [31:0] raddr; logic [31:0] rdat; logic [1:0] rresp; int nrd;
   } vec_t;

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      vec_t        tbl [7];
      logic [31:0] a, d, wa, ra, exp_d;
      logic [3:0]  s;
      logic [1:0]  resp;
      int          n, n0;
      logic        first_wr [2];

      tbl[0] = '{32'h010,  32'hDEADBEEF, 4'hF, 2'b00, 1, 32'h010,  32'hDEADBEEF, 2'b00, 1};
      tbl[1] = '{32'h010,  32'h11223344, 4'h3, 2'b00, 1, 32'h010,  32'hDEAD3344, 2'b00, 1};
      tbl[2] = '{32'h014,  32'hAABBCCDD, 4'h0, 2'b00, 0, 32'h014,  32'h00000000, 2'b00, 1};
      tbl[3] = '{32'h2000, 32'h12345678, 4'hF, 2'b11, 0, 32'h2000, 32'h00000000, 2'b11, 0};
      tbl[4] = '{32'hFFC,  32'hCAFEF00D, 4'hC, 2'b00, 1, 32'hFFC,  32'hCAFE0000, 2'b00, 1};
      tbl[5] = '{32'h1000, 32'h00000001, 4'hF, 2'b11, 0, 32'h1000, 32'h00000000, 2'b11, 0};
      tbl[6] = '{32'h013,  32'h000000A5, 4'h1, 2'b00, 1, 32'h011,  32'hDEAD33A5, 2'b00, 1};

      // Reset state and ready release
      #2;
      check("rst_awready", awready, 0); check("rst_arready", arready, 0);
      check("rst_bvalid", bvalid, 0);   check("rst_rvalid", rvalid, 0);
      check("rst_reg_wr", {reg_wr, reg_rd}, 0); check("rst_reg_addr", reg_addr, 0);
      check("rst_rdata", rdata, 0);
      @(posedge clk); #2 resetn = 1'b1;
      #1 check("rel_ready_early", {awready, wready, arready}, 3'b000);
      @(posedge clk); #1;
      check("rel_ready", {awready, wready, arready}, 3'b111);

      for (int i = 0; i < 7; i++) begin
         axi_write(tbl[i].waddr, tbl[i].wdat, tbl[i].strb, resp, n);
         model_write(tbl[i].waddr, tbl[i].wdat, tbl[i].strb);
         check("tbl_bresp", resp, tbl[i].bresp);
         check("tbl_nwr", n, tbl[i].nwr);
         if (tbl[i].nwr == 1) check("tbl_wr_addr", last_wr_addr, tbl[i].waddr & 32'hFFFF_FFFC);
         axi_read(tbl[i].raddr, d, resp, n);
         check("tbl_rdata", d, tbl[i].rdat);
         check("tbl_rresp", resp, tbl[i].rresp);
         check("tbl_nrd", n, tbl[i].nrd);
      end

      // Same-cycle AW and W, minimum write latency
      bready = 1'b1; awaddr = 32'h10; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk); check("w041_ready", {awready, wready}, 2'b11);
      @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      check("w041_reg_wr", reg_wr, 1); check("w041_reg_addr", reg_addr, 32'h10);
      check("w041_reg_wdata", reg_wdata, 32'hDEADBEEF); check("w041_bvalid_c1", bvalid, 0);
      @(negedge clk);
      check("w041_bvalid_c2", bvalid, 1); check("w041_bresp", bresp, 2'b00); check("w041_wr_c2", reg_wr, 0);
      @(negedge clk); check("w041_bvalid_drop", bvalid, 0);
      @(posedge clk); #1; bready = 1'b0;
      model_write(32'h10, 32'hDEADBEEF, 4'hF);

      // W three cycles ahead of AW
      wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
      @(negedge clk); check("w042_wready", wready, 1);
      @(posedge clk); #1; wvalid = 1'b0; n0 = wr_pulses;
      @(negedge clk); check("w042_wready_drop", wready, 0); check("w042_awready", awready, 1);
      @(posedge clk); #1;
      @(posedge clk); #1; awaddr = 32'h20; awvalid = 1'b1;
      @(negedge clk); check("w042_no_early_wr", wr_pulses - n0, 0);
      @(posedge clk); #1; awvalid = 1'b0; bready = 1'b1;
      @(negedge clk);
      check("w042_reg_wr", reg_wr, 1); check("w042_wdata", reg_wdata, 32'h55); check("w042_addr", reg_addr, 32'h20);
      @(negedge clk); check("w042_bvalid", bvalid, 1);
      @(posedge clk); #1; bready = 1'b0;
      model_write(32'h20, 32'h55, 4'hF);

      // RD_LAT=2 read with stalled rready
      rd_override = 1'b1; rd_force = 32'h1111_1111; araddr = 32'h8; arvalid = 1'b1;
      @(negedge clk); check("r043_arready", arready, 1);
      @(posedge clk); #1; arvalid = 1'b0;
      @(negedge clk); check("r043_reg_rd", reg_rd, 1); check("r043_addr", reg_addr, 32'h8);
      @(posedge clk); #1;
      @(negedge clk); check("r043_rvalid_c2", rvalid, 0);
      @(posedge clk); #1; rd_force = 32'h0000_CAFE;
      @(negedge clk); check("r043_rvalid_c3", rvalid, 0);
      @(posedge clk); #1; rd_force = 32'h1111_1111;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("r043_rvalid_hold", rvalid, 1); check("r043_rdata_hold", rdata, 32'h0000_CAFE);
         @(posedge clk); #1;
      end
      rready = 1'b1;
      @(negedge clk); check("r043_rresp", rresp, 2'b00);
      @(posedge clk); #1; rready = 1'b0;
      @(negedge clk); check("r043_rvalid_drop", rvalid, 0);
      @(posedge clk); #1; rd_override = 1'b0;

      // Reset with both responses pending
      awaddr = 32'h80; wdata = 32'h0BAD_F00D; wstrb = 4'hF; araddr = 32'h84;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk); check("r046_pending", {bvalid, rvalid}, 2'b11);
      #2 resetn = 1'b0;
      #1;
      check("r046_valids", {bvalid, rvalid}, 2'b00);
      check("r046_readies", {awready, wready, arready}, 3'b000);
      check("r046_strobes", {reg_wr, reg_rd}, 2'b00);
      check("r046_rdata", rdata, 0); check("r046_reg_addr", reg_addr, 0);
      model_write(32'h80, 32'h0BAD_F00D, 4'hF);
      @(posedge clk); @(posedge clk); #2 resetn = 1'b1;
      #1 check("r046_ready_early", {awready, wready, arready}, 3'b000);
      @(posedge clk); #1;
      check("r046_ready_rel", {awready, wready, arready}, 3'b111);

      // Read/write issue collisions must alternate
      bready = 1'b1; rready = 1'b1;
      for (int r = 0; r < 2; r++) begin
         wa = 32'h40 + 32'(8 * r); ra = 32'h44 + 32'(8 * r);
         awaddr = wa; wdata = 32'hA000_0000 + 32'(r); wstrb = 4'hF; araddr = ra;
         awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
         @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
         @(negedge clk);
         check("a045_single_grant", 32'(reg_wr) + 32'(reg_rd), 1);
         first_wr[r] = reg_wr;
         if (r == 1) check("a045_alternate", reg_wr, !first_wr[0]);
         check("a045_c1_addr", reg_addr, first_wr[r] ? wa : ra);
         @(negedge clk);
         check("a045_loser_wr", reg_wr, !first_wr[r]);
         check("a045_loser_rd", reg_rd, first_wr[r]);
         check("a045_c2_addr", reg_addr, first_wr[r] ? ra : wa);
         model_write(wa, 32'hA000_0000 + 32'(r), 4'hF);
         repeat (8) @(posedge clk);
         #1;
      end
      bready = 1'b0; rready = 1'b0;

      // Randomized traffic against the memory model
      for (int i = 0; i < 60; i++) begin
         a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(32'h1000, 32'h1FFF)) : 32'($urandom_range(0, 63));
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom; s = 4'($urandom_range(0, 15));
            axi_write(a, d, s, resp, n);
            check("rnd_bresp", resp, (a < REG_SPACE) ? 2'b00 : 2'b11);
            check("rnd_nwr", n, (a < REG_SPACE && s != 4'h0) ? 1 : 0);
            model_write(a, d, s);
         end else begin
            axi_read(a, d, resp, n);
            exp_d = (a < REG_SPACE) ? model_mem[a[11:2]] : 32'h0;
            check("rnd_rdata", d, exp_d);
            check("rnd_rresp", resp, (a < REG_SPACE) ? 2'b00 : 2'b11);
            check("rnd_nrd", n, (a < REG_SPACE) ? 1 : 0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
